// File: rtl/sram_responder.sv
// Byte-wide asynchronous-SRAM target model with registered pin sampling,
// write-strobe width checking, access statistics and sticky protocol errors.
module sram_responder #(
  parameter int unsigned ADDR_BITS     = 15,
  parameter int unsigned MIN_WE_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset_b,
  input  logic        ram_cs_b,
  input  logic        ram_oe_b,
  input  logic        ram_we_b,
  input  logic [18:0] ram_addr,
  inout  logic [7:0]  ram_data,
  input  logic        clr_stats,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic        err_short_we,
  output logic        err_overlap,
  output logic        err_range
);

  localparam int unsigned DEPTH  = 1 << ADDR_BITS;
  localparam logic [2:0]  MIN_WE = 3'(MIN_WE_CYCLES);

  logic                 s_cs_b, s_oe_b, s_we_b;
  logic [18:0]          s_addr;
  logic [7:0]           s_data;

  logic [2:0]           we_cnt;
  logic [18:0]          cap_addr;
  logic [7:0]           cap_data;

  logic                 drive_en;
  logic                 byp_q;
  logic [7:0]           byp_data;
  logic [7:0]           mem_q;
  logic [7:0]           rd_byte;

  logic                 prev_rd;
  logic [18:0]          prev_addr;

  logic [7:0]           mem [0:DEPTH-1];

  logic                 wr_low, wr_end, commit, short_we;
  logic                 rd_cond, rd_new, bypass, overlap, range_hit;
  logic                 s_hi, cap_hi;
  logic [ADDR_BITS-1:0] s_idx, cap_idx;

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      s_cs_b <= 1'b1;
      s_oe_b <= 1'b1;
      s_we_b <= 1'b1;
      s_addr <= '0;
      s_data <= '0;
    end else begin
      s_cs_b <= ram_cs_b;
      s_oe_b <= ram_oe_b;
      s_we_b <= ram_we_b;
      s_addr <= ram_addr;
      s_data <= ram_data;
    end
  end

  always_comb begin
    s_idx     = s_addr[ADDR_BITS-1:0];
    cap_idx   = cap_addr[ADDR_BITS-1:0];
    s_hi      = |s_addr[18:ADDR_BITS];
    cap_hi    = |cap_addr[18:ADDR_BITS];
    wr_low    = !s_cs_b && !s_we_b;
    wr_end    = !wr_low && (we_cnt != 3'd0);
    commit    = wr_end && (we_cnt >= MIN_WE) && !cap_hi;
    short_we  = wr_end && (we_cnt < MIN_WE);
    rd_cond   = !s_cs_b && !s_oe_b && s_we_b;
    rd_new    = rd_cond && (!prev_rd || (s_addr != prev_addr));
    bypass    = commit && (cap_idx == s_idx);
    overlap   = !s_cs_b && !s_oe_b && !s_we_b;
    range_hit = !s_cs_b && (!s_oe_b || !s_we_b) && s_hi;
  end

  // Store kept reset-free so it maps to plain RAM; the bypass flag selects the
  // byte being committed in the same cycle as the read.
  always_ff @(posedge clock) begin
    if (commit) begin
      mem[cap_idx] <= cap_data;
    end
    mem_q <= mem[s_idx];
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      we_cnt       <= '0;
      cap_addr     <= '0;
      cap_data     <= '0;
      drive_en     <= 1'b0;
      byp_q        <= 1'b0;
      byp_data     <= '0;
      prev_rd      <= 1'b0;
      prev_addr    <= '0;
      rd_count     <= '0;
      wr_count     <= '0;
      err_short_we <= 1'b0;
      err_overlap  <= 1'b0;
      err_range    <= 1'b0;
    end else begin
      drive_en  <= rd_cond;
      byp_q     <= bypass;
      byp_data  <= cap_data;
      prev_rd   <= rd_cond;
      prev_addr <= s_addr;

      if (wr_low) begin
        if (we_cnt != 3'd7) begin
          we_cnt <= we_cnt + 3'd1;
        end
        cap_addr <= s_addr;
        cap_data <= s_data;
      end else begin
        we_cnt <= '0;
      end

      if (clr_stats) begin
        rd_count     <= '0;
        wr_count     <= '0;
        err_short_we <= 1'b0;
        err_overlap  <= 1'b0;
        err_range    <= 1'b0;
      end else begin
        if (rd_new && (rd_count != '1)) begin
          rd_count <= rd_count + 16'd1;
        end
        if (commit && (wr_count != '1)) begin
          wr_count <= wr_count + 16'd1;
        end
        if (short_we) begin
          err_short_we <= 1'b1;
        end
        if (overlap) begin
          err_overlap <= 1'b1;
        end
        if (range_hit) begin
          err_range <= 1'b1;
        end
      end
    end
  end

  assign rd_byte  = byp_q ? byp_data : mem_q;
  assign ram_data = drive_en ? rd_byte : 'z;

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: reads queue their expected byte at drive
// time and are compared when the DUT drives the bus two edges later.
module tb_sram_responder;

  localparam int unsigned AB  = 15;
  localparam int unsigned MIN = 2;

  logic        clock = 1'b0;
  logic        reset_b;
  logic        ram_cs_b, ram_oe_b, ram_we_b;
  logic [18:0] ram_addr;
  wire  [7:0]  ram_data;
  logic        clr_stats;
  logic [15:0] rd_count, wr_count;
  logic        err_short_we, err_overlap, err_range;

  logic        tb_drv;
  logic [7:0]  tb_data;

  assign ram_data = tb_drv ? tb_data : 'z;

  always #5 clock = ~clock;

  sram_responder #(.ADDR_BITS(AB), .MIN_WE_CYCLES(MIN)) dut (
    .clock        (clock),
    .reset_b      (reset_b),
    .ram_cs_b     (ram_cs_b),
    .ram_oe_b     (ram_oe_b),
    .ram_we_b     (ram_we_b),
    .ram_addr     (ram_addr),
    .ram_data     (ram_data),
    .clr_stats    (clr_stats),
    .rd_count     (rd_count),
    .wr_count     (wr_count),
    .err_short_we (err_short_we),
    .err_overlap  (err_overlap),
    .err_range    (err_range)
  );

  typedef struct {
    int unsigned due;
    logic [7:0]  data;
  } rd_exp_t;

  rd_exp_t     sb[$];
  int unsigned cyc, checks, errors;
  logic [7:0]  model [0:(1<<AB)-1];
  int unsigned exp_rd, exp_wr, wl;
  logic        exp_short, exp_ovl, exp_rng;
  logic        prev_rd;
  logic [18:0] prev_addr, cap_a;
  logic [7:0]  cap_d;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    rd_exp_t e;
    @(posedge clock);
    #1;
    cyc++;
    if (sb.size() != 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("rd_data", {24'd0, ram_data}, {24'd0, e.data});
    end else if (tb_drv) begin
      check("bus_contention", {24'd0, ram_data}, {24'd0, tb_data});
    end else begin
      check("hiz", {24'd0, ram_data}, {24'd0, 8'hzz});
    end
  endtask

  task automatic drive(input logic cs, input logic oe, input logic we,
                       input logic [18:0] a, input logic [7:0] d);
    logic rd;
    ram_cs_b = cs;
    ram_oe_b = oe;
    ram_we_b = we;
    ram_addr = a;
    tb_data  = d;
    tb_drv   = !cs && !we;
    if (!cs && !oe && !we) exp_ovl = 1'b1;
    if (!cs && (!oe || !we) && (a[18:AB] != 0)) exp_rng = 1'b1;
    if (!cs && !we) begin
      if (wl < 7) wl++;
      cap_a = a;
      cap_d = d;
    end else if (wl != 0) begin
      if (wl < MIN) exp_short = 1'b1;
      else if (cap_a[18:AB] == 0) begin
        model[cap_a[AB-1:0]] = cap_d;
        if (exp_wr < 65535) exp_wr++;
      end
      wl = 0;
    end
    rd = !cs && !oe && we;
    if (rd) begin
      if ((!prev_rd || a != prev_addr) && exp_rd < 65535) exp_rd++;
      sb.push_back('{due: cyc + 2, data: model[a[AB-1:0]]});
    end
    prev_rd   = rd;
    prev_addr = a;
    tick();
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b1, 19'h0, 8'h00);
  endtask

  task automatic wr(input logic [18:0] a, input logic [7:0] d, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [18:0] a, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b1, a, 8'h00);
  endtask

  task automatic check_stats();
    check("rd_count", {16'd0, rd_count}, exp_rd);
    check("wr_count", {16'd0, wr_count}, exp_wr);
    check("err_short_we", {31'd0, err_short_we}, {31'd0, exp_short});
    check("err_overlap", {31'd0, err_overlap}, {31'd0, exp_ovl});
    check("err_range", {31'd0, err_range}, {31'd0, exp_rng});
  endtask

  task automatic clear_model_state();
    sb.delete();
    wl        = 0;
    exp_rd    = 0;
    exp_wr    = 0;
    exp_short = 1'b0;
    exp_ovl   = 1'b0;
    exp_rng   = 1'b0;
    prev_rd   = 1'b0;
    prev_addr = '0;
  endtask

  // Asserted mid-cycle so the bus must float without waiting for an edge.
  task automatic do_reset();
    #2;
    reset_b  = 1'b0;
    ram_cs_b = 1'b1;
    ram_oe_b = 1'b1;
    ram_we_b = 1'b1;
    tb_drv   = 1'b0;
    clear_model_state();
    #1;
    check("reset_hiz", {24'd0, ram_data}, {24'd0, 8'hzz});
    check_stats();
    @(negedge clock);
    reset_b = 1'b1;
    tick();
  endtask

  initial begin
    cyc = 0; checks = 0; errors = 0;
    for (int unsigned i = 0; i < (1 << AB); i++) model[i] = 8'h00;
    clear_model_state();
    cap_a = '0; cap_d = '0;
    reset_b = 1'b0; clr_stats = 1'b0;
    ram_cs_b = 1'b1; ram_oe_b = 1'b1; ram_we_b = 1'b1;
    ram_addr = '0; tb_data = '0; tb_drv = 1'b0;
    @(posedge clock); #1;
    do_reset();

    idle(2);
    wr(19'h00010, 8'hA5, 2);
    idle(3);
    check_stats();

    rd(19'h00010, 3);
    rd(19'h00011, 2);
    idle(3);
    check_stats();

    wr(19'h00020, 8'h3C, 1);
    idle(3);
    check_stats();
    rd(19'h00020, 1);
    idle(3);

    drive(1'b0, 1'b0, 1'b0, 19'h00050, 8'h11);
    idle(3);
    check_stats();

    wr(19'h40000, 8'h99, 2);
    idle(3);
    check_stats();
    rd(19'h40010, 1);
    rd(19'h00000, 1);
    idle(3);
    check_stats();

    wr(19'h00060, 8'h5A, 2);
    rd(19'h00060, 2);
    idle(3);
    wr(19'h00061, 8'hC3, 3);
    idle(3);
    rd(19'h00061, 1);
    idle(3);
    check_stats();

    clr_stats = 1'b1;
    exp_rd = 0; exp_wr = 0;
    exp_short = 1'b0; exp_ovl = 1'b0; exp_rng = 1'b0;
    idle(1);
    clr_stats = 1'b0;
    idle(1);
    check_stats();

    wr(19'h00030, 8'h77, 1);
    do_reset();
    idle(3);
    rd(19'h00030, 1);
    idle(3);
    check_stats();
    rd(19'h00010, 3);
    do_reset();
    idle(2);

    for (int unsigned i = 0; i < 70000; i++)
      rd((i % 2 == 0) ? 19'h00010 : 19'h00011, 1);
    idle(3);
    check_stats();
    check("rd_count_sat", {16'd0, rd_count}, 32'h0000FFFF);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
